// File: rtl/aes_avalon_regs_if.sv
// Avalon-MM slave bus bundle between software and the AES register front end.
interface aes_avalon_regs_if;
   logic        AVL_CS;
   logic        AVL_READ;
   logic        AVL_WRITE;
   logic [3:0]  AVL_ADDR;
   logic [3:0]  AVL_BYTE_EN;
   logic [31:0] AVL_WRITEDATA;
   logic [31:0] AVL_READDATA;

   modport master (
      output AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
      input  AVL_READDATA
   );

   modport slave (
      input  AVL_CS, AVL_READ, AVL_WRITE, AVL_ADDR, AVL_BYTE_EN, AVL_WRITEDATA,
      output AVL_READDATA
   );
endinterface

// File: rtl/aes_avalon_regs.sv
// Register front end for the AES decryption core: key/ciphertext load,
// start/done handshake with timeout, plaintext capture and status.
module aes_avalon_regs #(
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                   CLK,
   input  logic                   RESET,
   aes_avalon_regs_if.slave       avl,
   output logic                   AES_START,
   input  logic                   AES_DONE,
   output logic [127:0]           AES_KEY,
   output logic [127:0]           AES_MSG_ENC,
   input  logic [127:0]           AES_MSG_DEC,
   output logic [31:0]            EXPORT_DATA
);

   localparam int unsigned CNT_W    = 16;
   localparam int unsigned WORD_W   = 32;
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0]  ADDR_CTRL   = 4'd14;
   localparam logic [3:0]  ADDR_STATUS = 4'd15;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_e;

   state_e              state_q;
   logic [WORD_W-1:0]   rw_q  [8];
   logic [WORD_W-1:0]   dec_q [4];
   logic [CNT_W-1:0]    cnt_q;
   logic                done_q;
   logic                tmo_q;
   logic                start_q;
   logic [WORD_W-1:0]   rdata_q;

   logic [WORD_W-1:0]   wr_word_d;
   logic [WORD_W-1:0]   rdata_d;
   logic                busy_c;
   logic                wr_c;
   logic                rd_c;
   logic                ctrl_wr_c;
   logic                reg_wr_c;

   // Bus decode
   assign busy_c    = (state_q == S_RUN);
   assign wr_c      = avl.AVL_CS & avl.AVL_WRITE;
   assign rd_c      = avl.AVL_CS & avl.AVL_READ;
   assign ctrl_wr_c = wr_c & (avl.AVL_ADDR == ADDR_CTRL) & avl.AVL_BYTE_EN[0];
   assign reg_wr_c  = wr_c & ~avl.AVL_ADDR[3] & ~busy_c;

   // Byte-enable merge of write data into the addressed key/msg word
   always_comb begin
      wr_word_d = rw_q[avl.AVL_ADDR[2:0]];
      for (int i = 0; i < 4; i++) begin
         if (avl.AVL_BYTE_EN[i]) begin
            wr_word_d[8*i +: 8] = avl.AVL_WRITEDATA[8*i +: 8];
         end
      end
   end

   // Read mux, evaluated on pre-edge state so read+write returns the old value
   always_comb begin
      rdata_d = '0;
      if (!avl.AVL_ADDR[3]) begin
         rdata_d = rw_q[avl.AVL_ADDR[2:0]];
      end else if (avl.AVL_ADDR[3:2] == 2'b10) begin
         rdata_d = dec_q[avl.AVL_ADDR[1:0]];
      end else if (avl.AVL_ADDR == ADDR_CTRL) begin
         rdata_d = {31'b0, busy_c};
      end else if (avl.AVL_ADDR == ADDR_STATUS) begin
         rdata_d = {29'b0, tmo_q, busy_c, done_q};
      end
   end

   // Registers, read data and the IDLE/RUN/FIN control FSM
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= S_IDLE;
         for (int i = 0; i < 8; i++) rw_q[i] <= '0;
         for (int i = 0; i < 4; i++) dec_q[i] <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         tmo_q   <= 1'b0;
         start_q <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (rd_c) rdata_q <= rdata_d;
         if (reg_wr_c) rw_q[avl.AVL_ADDR[2:0]] <= wr_word_d;

         case (state_q)
            S_IDLE: begin
               if (ctrl_wr_c && avl.AVL_WRITEDATA[0]) begin
                  state_q <= S_RUN;
                  start_q <= 1'b1;
                  cnt_q   <= '0;
                  done_q  <= 1'b0;
                  tmo_q   <= 1'b0;
               end
            end
            S_RUN: begin
               cnt_q <= cnt_q + CNT_W'(1);
               // Done wins over a timeout landing on the same edge
               if (AES_DONE) begin
                  dec_q[0] <= AES_MSG_DEC[127:96];
                  dec_q[1] <= AES_MSG_DEC[95:64];
                  dec_q[2] <= AES_MSG_DEC[63:32];
                  dec_q[3] <= AES_MSG_DEC[31:0];
                  done_q   <= 1'b1;
                  start_q  <= 1'b0;
                  state_q  <= S_FIN;
               end else if (cnt_q == TMO_LAST) begin
                  done_q  <= 1'b1;
                  tmo_q   <= 1'b1;
                  start_q <= 1'b0;
                  state_q <= S_FIN;
               end
            end
            S_FIN: begin
               if (ctrl_wr_c) begin
                  done_q <= 1'b0;
                  tmo_q  <= 1'b0;
                  if (avl.AVL_WRITEDATA[0]) begin
                     state_q <= S_RUN;
                     start_q <= 1'b1;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               state_q <= S_IDLE;
               start_q <= 1'b0;
            end
         endcase
      end
   end

   assign avl.AVL_READDATA = rdata_q;
   assign AES_START        = start_q;
   assign AES_KEY          = {rw_q[0], rw_q[1], rw_q[2], rw_q[3]};
   assign AES_MSG_ENC      = {rw_q[4], rw_q[5], rw_q[6], rw_q[7]};
   assign EXPORT_DATA      = {rw_q[0][31:16], rw_q[3][15:0]};

endmodule

// File: tb/tb_aes_avalon_regs.sv
// Self-checking bench: two instances (default timeout and a short timeout of 8),
// directed sequence with randomized data against a register-map model.
module tb_aes_avalon_regs;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          done_a, done_b;
   logic [127:0]  dec_a, dec_b;
   logic          start_a, start_b;
   logic [127:0]  key_a, key_b, enc_a, enc_b;
   logic [31:0]   exp_a, exp_b;

   aes_avalon_regs_if bus_a ();
   aes_avalon_regs_if bus_b ();

   aes_avalon_regs dut_a (
      .CLK(clk), .RESET(rst_n), .avl(bus_a), .AES_START(start_a), .AES_DONE(done_a),
      .AES_KEY(key_a), .AES_MSG_ENC(enc_a), .AES_MSG_DEC(dec_a), .EXPORT_DATA(exp_a)
   );

   aes_avalon_regs #(.TIMEOUT_CYCLES(8)) dut_b (
      .CLK(clk), .RESET(rst_n), .avl(bus_b), .AES_START(start_b), .AES_DONE(done_b),
      .AES_KEY(key_b), .AES_MSG_ENC(enc_b), .AES_MSG_DEC(dec_b), .EXPORT_DATA(exp_b)
   );

   int total = 0;
   int bad   = 0;
   int unsigned cyc = 0;
   int sc_a = 0;
   int sc_b = 0;

   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (start_a === 1'b1) sc_a++;
      if (start_b === 1'b1) sc_b++;
   end

   // Reference model: register contents and status bits per instance
   logic [31:0] m_rw  [2][8];
   logic [31:0] m_dec [2][4];
   bit          m_busy [2];
   bit          m_done [2];
   bit          m_tmo  [2];

   task automatic check(string tag, logic [127:0] obs, logic [127:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         for (int i = 0; i < 8; i++) m_rw[s][i] = '0;
         for (int i = 0; i < 4; i++) m_dec[s][i] = '0;
         m_busy[s] = 0; m_done[s] = 0; m_tmo[s] = 0;
      end
   endtask

   function automatic logic [31:0] exp_read(int s, logic [3:0] a);
      if (a < 4'd8)        return m_rw[s][a[2:0]];
      else if (a < 4'd12)  return m_dec[s][a[1:0]];
      else if (a == 4'd14) return {31'b0, m_busy[s]};
      else if (a == 4'd15) return {29'b0, m_tmo[s], m_busy[s], m_done[s]};
      return 32'h0;
   endfunction

   task automatic model_write(int s, logic [3:0] a, logic [31:0] d, logic [3:0] be);
      if (m_busy[s]) return;
      if (a < 4'd8) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) m_rw[s][a[2:0]][8*i +: 8] = d[8*i +: 8];
      end else if (a == 4'd14 && be[0]) begin
         m_done[s] = 0;
         m_tmo[s]  = 0;
         if (d[0]) m_busy[s] = 1;
      end
   endtask

   task automatic model_capture(int s, logic [127:0] v);
      m_dec[s][0] = v[127:96]; m_dec[s][1] = v[95:64];
      m_dec[s][2] = v[63:32];  m_dec[s][3] = v[31:0];
      m_busy[s] = 0; m_done[s] = 1; m_tmo[s] = 0;
   endtask

   task automatic drive(int s, bit cs, bit r, bit w, logic [3:0] a, logic [31:0] d, logic [3:0] be);
      if (s == 0) begin
         bus_a.AVL_CS = cs; bus_a.AVL_READ = r; bus_a.AVL_WRITE = w;
         bus_a.AVL_ADDR = a; bus_a.AVL_WRITEDATA = d; bus_a.AVL_BYTE_EN = be;
      end else begin
         bus_b.AVL_CS = cs; bus_b.AVL_READ = r; bus_b.AVL_WRITE = w;
         bus_b.AVL_ADDR = a; bus_b.AVL_WRITEDATA = d; bus_b.AVL_BYTE_EN = be;
      end
   endtask

   // One bus cycle, entered and left at a falling edge; reads are checked against the model
   task automatic op(int s, bit r, bit w, logic [3:0] a, logic [31:0] d, logic [3:0] be,
                     string tag, output logic [31:0] q);
      logic [31:0] pre;
      pre = exp_read(s, a);
      drive(s, 1'b1, r, w, a, d, be);
      @(negedge clk);
      drive(s, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
      q = (s == 0) ? bus_a.AVL_READDATA : bus_b.AVL_READDATA;
      if (r) check(tag, q, pre);
      if (w) model_write(s, a, d, be);
   endtask

   task automatic wr(int s, logic [3:0] a, logic [31:0] d, logic [3:0] be);
      logic [31:0] q;
      op(s, 1'b0, 1'b1, a, d, be, "", q);
   endtask

   task automatic rd(int s, string tag, logic [3:0] a, output logic [31:0] q);
      op(s, 1'b1, 1'b0, a, 32'd0, 4'd0, tag, q);
   endtask

   task automatic rd_dec(int s, string tag);
      logic [31:0] q;
      for (int i = 8; i < 12; i++) rd(s, tag, 4'(i), q);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0]  q;
      logic [127:0] v;
      int unsigned  n0;
      int           lat;

      rst_n = 1'b0; done_a = 1'b0; done_b = 1'b0; dec_a = '0; dec_b = '0;
      drive(0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
      drive(1, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Reset clears a previously written key
      wr(0, 4'd0, 32'hDEADBEEF, 4'hF);
      check("key0_loaded", key_a[127:96], 32'hDEADBEEF);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check("rst_start", start_a, 1'b0);
      check("rst_export", exp_a, 32'h0);
      check("rst_rdata", bus_a.AVL_READDATA, 32'h0);
      for (int i = 0; i < 16; i++) rd(0, "rst_read", 4'(i), q);

      // Byte enables
      wr(0, 4'd0, 32'h11223344, 4'hF);
      wr(0, 4'd0, 32'hAAAAAAAA, 4'b0101);
      rd(0, "be_read", 4'd0, q);
      check("be_value", q, 32'h11AA33AA);
      check("be_key", key_a[127:96], 32'h11AA33AA);
      check("be_export_hi", exp_a[31:16], 16'h11AA);

      // Random load of remaining key/msg words, ignored writes to RO/reserved
      for (int i = 1; i < 8; i++) wr(0, 4'(i), $urandom, 4'hF);
      wr(0, 4'd9, $urandom, 4'hF);
      wr(0, 4'd12, $urandom, 4'hF);
      wr(0, 4'd15, $urandom, 4'hF);
      drive(0, 1'b0, 1'b0, 1'b1, 4'd5, 32'h5A5A5A5A, 4'hF);
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
      for (int i = 0; i < 16; i++) rd(0, "load_read", 4'(i), q);
      check("key_bus", key_a, {m_rw[0][0], m_rw[0][1], m_rw[0][2], m_rw[0][3]});
      check("enc_bus", enc_a, {m_rw[0][4], m_rw[0][5], m_rw[0][6], m_rw[0][7]});
      check("export", exp_a, {m_rw[0][0][31:16], m_rw[0][3][15:0]});

      // Simultaneous read and write returns the pre-write value
      op(0, 1'b1, 1'b1, 4'd3, $urandom, 4'hF, "rdwr_old", q);
      rd(0, "rdwr_new", 4'd3, q);

      // Normal run with done after 20 cycles; writes locked while busy
      sc_a = 0;
      wr(0, 4'd14, 32'd1, 4'b0001);
      n0 = cyc;
      check("run_start_hi", start_a, 1'b1);
      rd(0, "run_status", 4'd15, q);
      check("run_status_const", q, 32'h2);
      wr(0, 4'd4, 32'hFFFFFFFF, 4'hF);
      rd(0, "run_lock_reg4", 4'd4, q);
      check("run_lock_enc", enc_a, {m_rw[0][4], m_rw[0][5], m_rw[0][6], m_rw[0][7]});
      rd(0, "run_ctrl_busy", 4'd14, q);
      while (cyc < n0 + 19) @(negedge clk);
      v = {2{64'h0123456789ABCDEF}};
      done_a = 1'b1; dec_a = v;
      @(negedge clk);
      done_a = 1'b0;
      model_capture(0, v);
      check("run_start_len", sc_a, 20);
      check("run_start_lo", start_a, 1'b0);
      rd(0, "done_status", 4'd15, q);
      check("done_status_const", q, 32'h1);
      rd(0, "dec8", 4'd8, q);
      check("dec8_const", q, 32'h01234567);
      rd(0, "dec9", 4'd9, q);
      check("dec9_const", q, 32'h89ABCDEF);
      rd_dec(0, "dec_read");

      // AES_DONE ignored outside RUN; writes accepted in FIN
      done_a = 1'b1; dec_a = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      done_a = 1'b0;
      rd_dec(0, "fin_done_ignored");
      wr(0, 4'd5, $urandom, 4'hF);
      rd(0, "fin_write", 4'd5, q);
      wr(0, 4'd14, 32'd0, 4'b0001);
      rd(0, "idle_status", 4'd15, q);

      // Randomized runs with random done latency
      for (int k = 0; k < 4; k++) begin
         wr(0, 4'(4 + k), $urandom, 4'($urandom_range(0, 15)));
         lat  = $urandom_range(1, 30);
         sc_a = 0;
         wr(0, 4'd14, 32'd1, 4'b0001);
         n0 = cyc;
         while (cyc < n0 + lat - 1) @(negedge clk);
         v = {$urandom, $urandom, $urandom, $urandom};
         done_a = 1'b1; dec_a = v;
         @(negedge clk);
         done_a = 1'b0;
         model_capture(0, v);
         check("rnd_start_len", sc_a, lat);
         rd(0, "rnd_status", 4'd15, q);
         rd_dec(0, "rnd_dec");
         if (k[0]) wr(0, 4'd14, 32'd0, 4'b0001);
      end

      // Short-timeout instance: done on the exact timeout edge wins
      for (int i = 0; i < 8; i++) wr(1, 4'(i), $urandom, 4'hF);
      sc_b = 0;
      wr(1, 4'd14, 32'd1, 4'b0001);
      n0 = cyc;
      while (cyc < n0 + 7) @(negedge clk);
      v = {$urandom, $urandom, $urandom, $urandom};
      done_b = 1'b1; dec_b = v;
      @(negedge clk);
      done_b = 1'b0;
      model_capture(1, v);
      check("edge_start_len", sc_b, 8);
      rd(1, "edge_status", 4'd15, q);
      check("edge_status_const", q, 32'h1);
      rd_dec(1, "edge_dec");

      // Timeout: restart from FIN, never assert done
      sc_b = 0;
      dec_b = {$urandom, $urandom, $urandom, $urandom};
      wr(1, 4'd14, 32'd1, 4'b0001);
      n0 = cyc;
      while (cyc < n0 + 7) @(negedge clk);
      rd(1, "to_pre_status", 4'd15, q);
      m_busy[1] = 0; m_done[1] = 1; m_tmo[1] = 1;
      check("to_start_len", sc_b, 8);
      check("to_start_lo", start_b, 1'b0);
      rd(1, "to_status", 4'd15, q);
      check("to_status_const", q, 32'h5);
      rd_dec(1, "to_dec_kept");
      wr(1, 4'd14, 32'd0, 4'b0001);
      rd(1, "to_clear_status", 4'd15, q);
      check("to_clear_const", q, 32'h0);

      // Reset asserted mid-RUN
      wr(0, 4'd14, 32'd1, 4'b0001);
      wr(1, 4'd14, 32'd1, 4'b0001);
      repeat (3) @(negedge clk);
      check("midrun_busy", start_a, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check("midrun_start_a", start_a, 1'b0);
      check("midrun_start_b", start_b, 1'b0);
      check("midrun_export", exp_a, 32'h0);
      rd(0, "midrun_status", 4'd15, q);
      rd(0, "midrun_key0", 4'd0, q);
      rd_dec(0, "midrun_dec");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
